checkpoint_recovery_ctrl: RTL and testbench

- Sequences branch-misprediction recovery around the checkpoint buffer in the rename/dispatch region.
- Arbitrates mispredict reports from NUM_BRU branch units and picks the oldest by ROB age.
- Drives the checkpoint restore pulse, a multi-cycle pipeline flush and the fetch redirect.
- Gates checkpoint allocation and dispatch until recovery completes.

---
 rtl/checkpoint_recovery_ctrl_pkg.sv | 34 +++
 rtl/checkpoint_recovery_ctrl_if.sv | 41 ++++
 rtl/checkpoint_recovery_ctrl_oldest_select.sv | 44 ++++
 rtl/checkpoint_recovery_ctrl.sv | 133 +++++++++++++
 tb/tb_checkpoint_recovery_ctrl.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/checkpoint_recovery_ctrl_pkg.sv
// Shared types and tag-age helpers for the branch recovery controller.
// Tag ages are taken relative to the ROB head, modulo the tag width.
package checkpoint_recovery_ctrl_pkg;

  localparam int ROB_TAG_W = 4;
  localparam int PC_W      = 32;

  typedef logic [ROB_TAG_W-1:0] rob_tag_t;
  typedef logic [PC_W-1:0]      pc_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RESTORE  = 2'd1,
    FLUSH    = 2'd2,
    REDIRECT = 2'd3
  } rec_state_e;

  // Width-agnostic so modules with any ROB_WIDTH can share it.
  function automatic logic [31:0] tag_age(input logic [31:0] tag,
                                          input logic [31:0] head,
                                          input int          width);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (tag - head) & mask;
  endfunction

  function automatic logic is_older(input logic [31:0] tag_a,
                                    input logic [31:0] tag_b,
                                    input logic [31:0] head,
                                    input int          width);
    return tag_age(tag_a, head, width) < tag_age(tag_b, head, width);
  endfunction

endpackage

// File: rtl/checkpoint_recovery_ctrl_if.sv
// Branch-resolution, dispatch and recovery signals of the recovery controller.
// The controller is the slave; the surrounding pipeline is the master.
interface checkpoint_recovery_ctrl_if #(
  parameter int ROB_WIDTH = 4,
  parameter int PC_WIDTH  = 32,
  parameter int NUM_BRU   = 2
);

  logic [ROB_WIDTH-1:0]          i_rob_head_tag;
  logic [NUM_BRU-1:0]            i_bru_valid;
  logic [NUM_BRU-1:0]            i_bru_mispredict;
  logic [NUM_BRU*ROB_WIDTH-1:0]  i_bru_tag;
  logic [NUM_BRU*PC_WIDTH-1:0]   i_bru_target;
  logic                          i_branch_dispatch;
  logic                          i_ckpt_full;

  logic                          o_ckpt_alloc;
  logic                          o_ckpt_restore;
  logic [ROB_WIDTH-1:0]          o_restore_tag;
  logic                          o_flush;
  logic [ROB_WIDTH-1:0]          o_flush_tag;
  logic                          o_redirect_valid;
  logic [PC_WIDTH-1:0]           o_redirect_pc;
  logic                          o_stall_dispatch;
  logic                          o_busy;

  modport slave (
    input  i_rob_head_tag, i_bru_valid, i_bru_mispredict, i_bru_tag,
           i_bru_target, i_branch_dispatch, i_ckpt_full,
    output o_ckpt_alloc, o_ckpt_restore, o_restore_tag, o_flush, o_flush_tag,
           o_redirect_valid, o_redirect_pc, o_stall_dispatch, o_busy
  );

  modport master (
    output i_rob_head_tag, i_bru_valid, i_bru_mispredict, i_bru_tag,
           i_bru_target, i_branch_dispatch, i_ckpt_full,
    input  o_ckpt_alloc, o_ckpt_restore, o_restore_tag, o_flush, o_flush_tag,
           o_redirect_valid, o_redirect_pc, o_stall_dispatch, o_busy
  );

endinterface

// File: rtl/checkpoint_recovery_ctrl_oldest_select.sv
// Combinational N-way picker returning the oldest requesting tag by ROB age.
// Ties go to the lowest port index.
module checkpoint_recovery_ctrl_oldest_select
  import checkpoint_recovery_ctrl_pkg::*;
#(
  parameter  int NUM       = 2,
  parameter  int ROB_WIDTH = 4,
  parameter  int PC_WIDTH  = 32,
  localparam int IDX_W     = (NUM > 1) ? $clog2(NUM) : 1
) (
  input  logic [ROB_WIDTH-1:0]     head_tag,
  input  logic [NUM-1:0]           req,
  input  logic [NUM*ROB_WIDTH-1:0] tags,
  input  logic [NUM*PC_WIDTH-1:0]  targets,
  output logic                     sel_valid,
  output logic [IDX_W-1:0]         sel_idx,
  output logic [ROB_WIDTH-1:0]     sel_tag,
  output logic [PC_WIDTH-1:0]      sel_target
);

  logic [31:0] best_age;
  logic [31:0] cand_age;

  always_comb begin
    sel_valid  = 1'b0;
    sel_idx    = '0;
    sel_tag    = '0;
    sel_target = '0;
    best_age   = '0;
    cand_age   = '0;
    for (int p = 0; p < NUM; p++) begin
      cand_age = tag_age(32'(tags[p*ROB_WIDTH +: ROB_WIDTH]), 32'(head_tag), ROB_WIDTH);
      // Strict compare keeps the earlier (lower-index) port on equal age.
      if (req[p] && (!sel_valid || (cand_age < best_age))) begin
        sel_valid  = 1'b1;
        sel_idx    = IDX_W'(p);
        sel_tag    = tags[p*ROB_WIDTH +: ROB_WIDTH];
        sel_target = targets[p*PC_WIDTH +: PC_WIDTH];
        best_age   = cand_age;
      end
    end
  end

endmodule

// File: rtl/checkpoint_recovery_ctrl.sv
// Branch-mispredict recovery sequencer: restore checkpoint, flush, redirect fetch.
// Gates checkpoint allocation and dispatch while a recovery is in flight.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IDLE     | no recovery; first mispredict candidate is captured
//   RESTORE  | one-cycle checkpoint restore strobe for the captured tag
//   FLUSH    | flush younger-than-tag state for FLUSH_CYCLES cycles
//   REDIRECT | one-cycle fetch redirect to the captured target
module checkpoint_recovery_ctrl
  import checkpoint_recovery_ctrl_pkg::*;
#(
  parameter int ROB_WIDTH    = ROB_TAG_W,
  parameter int PC_WIDTH     = PC_W,
  parameter int NUM_BRU      = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input logic                      clk,
  input logic                      reset,
  checkpoint_recovery_ctrl_if.slave bus
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam int IDX_W = (NUM_BRU > 1) ? $clog2(NUM_BRU) : 1;

  rec_state_e           state_q, state_d;
  logic [ROB_WIDTH-1:0] tag_q, tag_d;
  logic [PC_WIDTH-1:0]  target_q, target_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 sel_valid;
  logic [IDX_W-1:0]     unused_sel_idx;
  logic [ROB_WIDTH-1:0] sel_tag;
  logic [PC_WIDTH-1:0]  sel_target;
  logic                 late_older;
  logic                 busy;

  checkpoint_recovery_ctrl_oldest_select #(
    .NUM       (NUM_BRU),
    .ROB_WIDTH (ROB_WIDTH),
    .PC_WIDTH  (PC_WIDTH)
  ) u_oldest_select (
    .head_tag   (bus.i_rob_head_tag),
    .req        (bus.i_bru_valid & bus.i_bru_mispredict),
    .tags       (bus.i_bru_tag),
    .targets    (bus.i_bru_target),
    .sel_valid  (sel_valid),
    .sel_idx    (unused_sel_idx),
    .sel_tag    (sel_tag),
    .sel_target (sel_target)
  );

  // The oldest candidate is the only one that can pre-empt an ongoing recovery.
  assign late_older = (state_q != IDLE) && sel_valid &&
                      is_older(32'(sel_tag), 32'(tag_q), 32'(bus.i_rob_head_tag), ROB_WIDTH);

  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (sel_valid) begin
          tag_d    = sel_tag;
          target_d = sel_target;
          state_d  = RESTORE;
        end
      end
      RESTORE: begin
        if (late_older) begin
          tag_d    = sel_tag;
          target_d = sel_target;
        end else begin
          cnt_d   = CNT_W'(FLUSH_CYCLES);
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (late_older) begin
          tag_d    = sel_tag;
          target_d = sel_target;
          state_d  = RESTORE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = REDIRECT;
        end
      end
      REDIRECT: begin
        if (late_older) begin
          tag_d    = sel_tag;
          target_d = sel_target;
          state_d  = RESTORE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      tag_q    <= '0;
      target_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy                 = (state_q != IDLE);
  assign bus.o_busy           = busy;
  assign bus.o_ckpt_restore   = (state_q == RESTORE);
  assign bus.o_restore_tag    = (state_q == RESTORE) ? tag_q : '0;
  assign bus.o_flush          = (state_q == FLUSH);
  assign bus.o_flush_tag      = (state_q == FLUSH) ? tag_q : '0;

  // An older mispredict arriving in REDIRECT would send fetch down a path
  // that is about to be killed, so the pulse is withheld that cycle.
  assign bus.o_redirect_valid = (state_q == REDIRECT) && !late_older;
  assign bus.o_redirect_pc    = ((state_q == REDIRECT) && !late_older) ? target_q : '0;

  assign bus.o_stall_dispatch = busy | sel_valid |
                                (bus.i_branch_dispatch & bus.i_ckpt_full);
  assign bus.o_ckpt_alloc     = bus.i_branch_dispatch & ~bus.i_ckpt_full &
                                ~bus.o_stall_dispatch;

endmodule

// File: tb/tb_checkpoint_recovery_ctrl.sv
// Self-checking bench: directed recovery scenarios plus random traffic,
// compared every cycle against a cycle-timeline model of the recovery.
module tb_checkpoint_recovery_ctrl;

  localparam int RW  = 4;
  localparam int PW  = 32;
  localparam int NB  = 2;
  localparam int FC  = 2;
  localparam int MOD = 1 << RW;

  logic clk;
  logic reset;

  checkpoint_recovery_ctrl_if #(.ROB_WIDTH(RW), .PC_WIDTH(PW), .NUM_BRU(NB)) bif ();

  checkpoint_recovery_ctrl #(
    .ROB_WIDTH(RW), .PC_WIDTH(PW), .NUM_BRU(NB), .FLUSH_CYCLES(FC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Model: a recovery is a window of cycles starting at m_start (restore),
  // FC flush cycles after it, then one redirect cycle.
  bit          m_active = 1'b0;
  int          m_start  = 0;
  int          m_tag    = 0;
  logic [31:0] m_tgt    = '0;

  function automatic int age_of(input int tag, input int head);
    return (tag + MOD - head) % MOD;
  endfunction

  always @(negedge clk) begin
    int          head, w, w_age, w_tag, a, t;
    logic [31:0] w_tgt;
    bit          in_rec, older, e_busy, e_rst, e_flush, e_redir, e_stall, e_alloc;
    head  = int'(bif.i_rob_head_tag);
    w     = -1;
    w_age = 0;
    w_tag = 0;
    w_tgt = '0;
    for (int p = 0; p < NB; p++) begin
      if (bif.i_bru_valid[p] && bif.i_bru_mispredict[p]) begin
        t = int'(bif.i_bru_tag[p*RW +: RW]);
        a = age_of(t, head);
        if (w < 0 || a < w_age) begin
          w     = p;
          w_age = a;
          w_tag = t;
          w_tgt = bif.i_bru_target[p*PW +: PW];
        end
      end
    end
    in_rec  = m_active && cyc >= m_start && cyc <= m_start + FC + 1;
    older   = in_rec && (w >= 0) && (w_age < age_of(m_tag, head));
    e_busy  = in_rec;
    e_rst   = in_rec && cyc == m_start;
    e_flush = in_rec && cyc > m_start && cyc <= m_start + FC;
    e_redir = in_rec && cyc == m_start + FC + 1 && !older;
    e_stall = e_busy || (w >= 0) || (bif.i_branch_dispatch && bif.i_ckpt_full);
    e_alloc = bif.i_branch_dispatch && !bif.i_ckpt_full && !e_stall;

    if (cyc > 0) begin
      chk("busy",        32'(bif.o_busy),           32'(e_busy));
      chk("restore",     32'(bif.o_ckpt_restore),   32'(e_rst));
      chk("restore_tag", 32'(bif.o_restore_tag),    e_rst ? 32'(m_tag) : 32'd0);
      chk("flush",       32'(bif.o_flush),          32'(e_flush));
      chk("flush_tag",   32'(bif.o_flush_tag),      e_flush ? 32'(m_tag) : 32'd0);
      chk("redirect",    32'(bif.o_redirect_valid), 32'(e_redir));
      chk("redirect_pc", bif.o_redirect_pc,         e_redir ? m_tgt : 32'd0);
      chk("stall",       32'(bif.o_stall_dispatch), 32'(e_stall));
      chk("alloc",       32'(bif.o_ckpt_alloc),     32'(e_alloc));
    end

    if (reset) begin
      m_active = 1'b0;
    end else if ((!in_rec && w >= 0) || older) begin
      m_active = 1'b1;
      m_start  = cyc + 1;
      m_tag    = w_tag;
      m_tgt    = w_tgt;
    end else if (in_rec && cyc == m_start + FC + 1) begin
      m_active = 1'b0;
    end
    cyc++;
  end

  task automatic clr();
    bif.i_bru_valid       = '0;
    bif.i_bru_mispredict  = '0;
    bif.i_bru_tag         = '0;
    bif.i_bru_target      = '0;
    bif.i_branch_dispatch = 1'b0;
    bif.i_ckpt_full       = 1'b0;
  endtask

  task automatic bru(input int p, input int tag, input logic [31:0] tgt);
    bif.i_bru_valid[p]           = 1'b1;
    bif.i_bru_mispredict[p]      = 1'b1;
    bif.i_bru_tag[p*RW +: RW]    = RW'(tag);
    bif.i_bru_target[p*PW +: PW] = tgt;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bif.i_rob_head_tag = '0;
    clr();
    tick(2);
    reset = 1'b0;
    tick(1);

    // single mispredict
    bif.i_rob_head_tag = RW'(0);
    bru(0, 3, 32'h100); tick(1); clr(); tick(6);

    // simultaneous, wrap-around age
    bif.i_rob_head_tag = RW'(14);
    bru(0, 5, 32'h500); bru(1, 1, 32'h111); tick(1); clr(); tick(6);

    // late older during flush
    bif.i_rob_head_tag = RW'(0);
    bru(0, 6, 32'h600); tick(1); clr(); tick(1);
    bru(1, 4, 32'h400); tick(1); clr(); tick(8);

    // late younger during flush
    bru(0, 4, 32'h440); tick(1); clr(); tick(1);
    bru(1, 8, 32'h880); tick(1); clr(); tick(6);

    // older mispredict landing on the redirect cycle
    bru(0, 9, 32'h990); tick(1); clr(); tick(3);
    bru(1, 2, 32'h220); tick(1); clr(); tick(8);

    // equal age on both ports: port 0 wins
    bru(0, 7, 32'hA0); bru(1, 7, 32'hB0); tick(1); clr(); tick(6);

    // allocation gating
    bif.i_branch_dispatch = 1'b1; bif.i_ckpt_full = 1'b1; tick(1);
    bif.i_ckpt_full = 1'b0; tick(1);
    bru(0, 5, 32'h55); tick(1);
    bif.i_bru_valid = '0; tick(5);
    clr(); tick(1);

    // reset in the middle of a flush
    bru(0, 7, 32'h777); tick(1); clr(); tick(2);
    reset = 1'b1; tick(1);
    reset = 1'b0; tick(6);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 119) == 0);
      if ($urandom_range(0, 7) == 0) bif.i_rob_head_tag = RW'($urandom_range(0, MOD - 1));
      for (int p = 0; p < NB; p++) begin
        bif.i_bru_valid[p]           = ($urandom_range(0, 4) == 0);
        bif.i_bru_mispredict[p]      = ($urandom_range(0, 3) != 0);
        bif.i_bru_tag[p*RW +: RW]    = RW'($urandom_range(0, MOD - 1));
        bif.i_bru_target[p*PW +: PW] = $urandom;
      end
      bif.i_branch_dispatch = $urandom_range(0, 1) == 1;
      bif.i_ckpt_full       = ($urandom_range(0, 3) == 0);
      tick(1);
    end
    reset = 1'b0;
    clr();
    tick(8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
